// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, flush and an optional
// two-entry skid buffer. The main register is the head entry and drives the
// MEM-side outputs. The skid register catches the one entry that EXE may send
// while MEM is stalled, so in_ready can come straight from a flop.
// A saturating counter records the cycles in which MEM holds off a valid entry.
module exe_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [DEST_W-1:0] dest,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_p0;
  state_t state_nxt;

  logic acc;
  logic pop;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  logic              main_wb_p0;
  logic              main_mr_p0;
  logic              main_mw_p0;
  logic [DATA_W-1:0] main_alu_p0;
  logic [DATA_W-1:0] main_st_p0;
  logic [DEST_W-1:0] main_dest_p0;

  logic              skid_wb_p1;
  logic              skid_mr_p1;
  logic              skid_mw_p1;
  logic [DATA_W-1:0] skid_alu_p1;
  logic [DATA_W-1:0] skid_st_p1;
  logic [DEST_W-1:0] skid_dest_p1;

  logic [CNT_W-1:0] stall_cnt_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign out_valid = (state_p0 != EMPTY);

  // With a skid slot, ready comes only from the state flop; without one it
  // must look at out_ready so a consuming head can be replaced without a bubble.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state_p0 != FULL);
    end else begin : g_comb_ready
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // Next occupancy and which register loads from where.
  always_comb begin
    state_nxt    = state_p0;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (acc) begin
            state_nxt  = HALF;
            ld_main_in = 1'b1;
          end
        end
        HALF: begin
          if (acc && pop) begin
            ld_main_in = 1'b1;
          end else if (acc && (SKID != 0)) begin
            state_nxt = FULL;
            ld_skid   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt    = HALF;
            ld_main_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // ---- stage p0: head entry, drives MEM ----
  // Flush clears only the control bits so a squashed entry can never act;
  // the payload is left alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_wb_p0   <= 1'b0;
      main_mr_p0   <= 1'b0;
      main_mw_p0   <= 1'b0;
      main_alu_p0  <= '0;
      main_st_p0   <= '0;
      main_dest_p0 <= '0;
    end else if (flush) begin
      main_wb_p0 <= 1'b0;
      main_mr_p0 <= 1'b0;
      main_mw_p0 <= 1'b0;
    end else if (ld_main_in) begin
      main_wb_p0   <= wb_en_in;
      main_mr_p0   <= mem_r_en_in;
      main_mw_p0   <= mem_w_en_in;
      main_alu_p0  <= alu_result_in;
      main_st_p0   <= st_val_in;
      main_dest_p0 <= dest_in;
    end else if (ld_main_skid) begin
      main_wb_p0   <= skid_wb_p1;
      main_mr_p0   <= skid_mr_p1;
      main_mw_p0   <= skid_mw_p1;
      main_alu_p0  <= skid_alu_p1;
      main_st_p0   <= skid_st_p1;
      main_dest_p0 <= skid_dest_p1;
    end
  end

  // ---- stage p1: skid entry, second in line behind the head ----
  // Captures the entry accepted while the head is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_wb_p1   <= 1'b0;
      skid_mr_p1   <= 1'b0;
      skid_mw_p1   <= 1'b0;
      skid_alu_p1  <= '0;
      skid_st_p1   <= '0;
      skid_dest_p1 <= '0;
    end else if (flush) begin
      skid_wb_p1 <= 1'b0;
      skid_mr_p1 <= 1'b0;
      skid_mw_p1 <= 1'b0;
    end else if (ld_skid) begin
      skid_wb_p1   <= wb_en_in;
      skid_mr_p1   <= mem_r_en_in;
      skid_mw_p1   <= mem_w_en_in;
      skid_alu_p1  <= alu_result_in;
      skid_st_p1   <= st_val_in;
      skid_dest_p1 <= dest_in;
    end
  end

  // Count cycles where MEM holds off a valid head; flush does not touch it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_p0 <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

  assign stall_cnt  = stall_cnt_p0;
  assign wb_en      = main_wb_p0 & out_valid;
  assign mem_r_en   = main_mr_p0 & out_valid;
  assign mem_w_en   = main_mw_p0 & out_valid;
  assign alu_result = main_alu_p0;
  assign st_val     = main_st_p0;
  assign dest       = main_dest_p0;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Bench for exe_mem_skid_reg: instance 0 has a skid buffer and a 16-bit
// counter, instance 1 has no skid buffer and a 2-bit counter. A queue-style
// model tracks what each instance must hold and is compared every cycle.
module tb_exe_mem_skid_reg;

  logic clk;
  logic rst;

  logic        fl[2];
  logic        iv[2];
  logic        ir[2];
  logic        wbi[2];
  logic        mri[2];
  logic        mwi[2];
  logic [31:0] alui[2];
  logic [31:0] sti[2];
  logic [3:0]  dsti[2];
  logic        ov[2];
  logic        ordy[2];
  logic        wbo[2];
  logic        mro[2];
  logic        mwo[2];
  logic [31:0] aluo[2];
  logic [31:0] sto[2];
  logic [3:0]  dsto[2];
  logic [15:0] stall0;
  logic [1:0]  stall1;

  int checks = 0;
  int errors = 0;

  exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .wb_en_in(wbi[0]), .mem_r_en_in(mri[0]), .mem_w_en_in(mwi[0]),
    .alu_result_in(alui[0]), .st_val_in(sti[0]), .dest_in(dsti[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .wb_en(wbo[0]), .mem_r_en(mro[0]), .mem_w_en(mwo[0]),
    .alu_result(aluo[0]), .st_val(sto[0]), .dest(dsto[0]),
    .stall_cnt(stall0)
  );

  exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(0), .CNT_W(2)) u_noskid (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .wb_en_in(wbi[1]), .mem_r_en_in(mri[1]), .mem_w_en_in(mwi[1]),
    .alu_result_in(alui[1]), .st_val_in(sti[1]), .dest_in(dsti[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .wb_en(wbo[1]), .mem_r_en(mro[1]), .mem_w_en(mwo[1]),
    .alu_result(aluo[1]), .st_val(sto[1]), .dest(dsto[1]),
    .stall_cnt(stall1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
  } ent_t;

  ent_t mq[2][2];
  int   mcnt[2];
  int   mstall[2];

  function automatic int cap(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int cnt_max(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  function automatic bit m_ready(input int i);
    if (i == 0) return (mcnt[0] < 2);
    return (mcnt[1] == 0) || ordy[1];
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      mcnt[i]   = 0;
      mstall[i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          mcnt[i]   = 0;
          mstall[i] = 0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          bit   acc;
          bit   pop;
          ent_t e;
          acc = iv[i] && m_ready(i);
          pop = (mcnt[i] > 0) && ordy[i];
          if ((mcnt[i] > 0) && !ordy[i] && (mstall[i] < cnt_max(i)))
            mstall[i]++;
          if (fl[i]) begin
            mcnt[i] = 0;
          end else begin
            if (pop) begin
              mq[i][0] = mq[i][1];
              mcnt[i]--;
            end
            if (acc && (mcnt[i] < cap(i))) begin
              e.wb   = wbi[i];
              e.mr   = mri[i];
              e.mw   = mwi[i];
              e.alu  = alui[i];
              e.st   = sti[i];
              e.dest = dsti[i];
              mq[i][mcnt[i]] = e;
              mcnt[i]++;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit   v;
        ent_t h;
        v = (mcnt[i] > 0);
        h = mq[i][0];
        chk($sformatf("out_valid%0d", i), 64'(ov[i]), 64'(v));
        chk($sformatf("in_ready%0d", i), 64'(ir[i]), 64'(m_ready(i)));
        chk($sformatf("wb_en%0d", i), 64'(wbo[i]), 64'(v & h.wb));
        chk($sformatf("mem_r_en%0d", i), 64'(mro[i]), 64'(v & h.mr));
        chk($sformatf("mem_w_en%0d", i), 64'(mwo[i]), 64'(v & h.mw));
        chk($sformatf("stall_cnt%0d", i), (i == 0) ? 64'(stall0) : 64'(stall1),
            64'(mstall[i]));
        if (v) begin
          chk($sformatf("alu_result%0d", i), 64'(aluo[i]), 64'(h.alu));
          chk($sformatf("st_val%0d", i), 64'(sto[i]), 64'(h.st));
          chk($sformatf("dest%0d", i), 64'(dsto[i]), 64'(h.dest));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] a,
                       input logic mw);
    iv[i]   = v;
    alui[i] = a;
    sti[i]  = a ^ 32'hFFFF_0000;
    dsti[i] = a[3:0];
    wbi[i]  = a[0];
    mri[i]  = a[1];
    mwi[i]  = mw;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 32'h0, 1'b0);
      fl[i]   = 1'b0;
      ordy[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_all();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_all();
    step();
    // Reset state
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", 64'(ov[i]), 64'd0);
      chk("rst_in_ready", 64'(ir[i]), 64'd1);
      chk("rst_alu", 64'(aluo[i]), 64'd0);
      chk("rst_st", 64'(sto[i]), 64'd0);
      chk("rst_dest", 64'(dsto[i]), 64'd0);
    end
    chk("rst_stall0", 64'(stall0), 64'd0);
    step();
    rst = 1'b1;

    // Streaming at full rate through the skid instance
    ordy[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1'b1, 32'(k), 1'b0);
      step();
      chk("stream_alu", 64'(aluo[0]), 64'(k));
      chk("stream_valid", 64'(ov[0]), 64'd1);
      chk("stream_ready", 64'(ir[0]), 64'd1);
    end
    drive(0, 1'b0, 32'h0, 1'b0);
    step();
    chk("stream_drain", 64'(ov[0]), 64'd0);

    // Back-pressure fills the skid slot
    ordy[0] = 1'b0;
    drive(0, 1'b1, 32'h10, 1'b0);
    step();
    drive(0, 1'b1, 32'h20, 1'b0);
    step();
    drive(0, 1'b0, 32'h0, 1'b0);
    chk("bp_full_ready", 64'(ir[0]), 64'd0);
    chk("bp_head", 64'(aluo[0]), 64'h10);
    ordy[0] = 1'b1;
    step();
    chk("bp_second", 64'(aluo[0]), 64'h20);
    chk("bp_ready_back", 64'(ir[0]), 64'd1);
    step();
    chk("bp_empty", 64'(ov[0]), 64'd0);

    // Flush while full of stores
    ordy[0] = 1'b0;
    drive(0, 1'b1, 32'h30, 1'b1);
    step();
    drive(0, 1'b1, 32'h40, 1'b1);
    step();
    chk("fl_mw_before", 64'(mwo[0]), 64'd1);
    fl[0] = 1'b1;
    drive(0, 1'b1, 32'h50, 1'b1);
    step();
    fl[0] = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0);
    chk("fl_valid", 64'(ov[0]), 64'd0);
    chk("fl_mw", 64'(mwo[0]), 64'd0);
    chk("fl_ready", 64'(ir[0]), 64'd1);
    ordy[0] = 1'b1;
    step();
    chk("fl_nothing_left", 64'(ov[0]), 64'd0);
    // Flush discards an entry accepted in the same cycle
    drive(0, 1'b1, 32'h60, 1'b0);
    step();
    fl[0] = 1'b1;
    drive(0, 1'b1, 32'h70, 1'b1);
    step();
    fl[0] = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0);
    chk("fl_acc_valid", 64'(ov[0]), 64'd0);
    step();
    chk("fl_acc_gone", 64'(ov[0]), 64'd0);

    // Stall counter counts and saturates
    do_reset();
    drive(0, 1'b1, 32'hA1, 1'b0);
    drive(1, 1'b1, 32'hB1, 1'b0);
    step();
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    repeat (5) step();
    chk("stall5", 64'(stall0), 64'd5);
    step();
    chk("stall_sat", 64'(stall1), 64'd3);

    // No-skid instance: combinational ready and bubble-free replacement
    chk("ns_ready_low", 64'(ir[1]), 64'd0);
    ordy[1] = 1'b1;
    drive(1, 1'b1, 32'h77, 1'b0);
    #1;
    chk("ns_ready_comb", 64'(ir[1]), 64'd1);
    step();
    chk("ns_replace", 64'(aluo[1]), 64'h77);
    chk("ns_valid", 64'(ov[1]), 64'd1);
    drive(1, 1'b1, 32'h78, 1'b0);
    step();
    chk("ns_replace2", 64'(aluo[1]), 64'h78);
    drive(1, 1'b0, 32'h0, 1'b0);
    ordy[1] = 1'b0;
    drive(1, 1'b1, 32'h79, 1'b0);
    step();
    drive(1, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset between edges
    drive(0, 1'b1, 32'hC3, 1'b1);
    step();
    drive(0, 1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("ar_valid", 64'(ov[i]), 64'd0);
      chk("ar_ready", 64'(ir[i]), 64'd1);
      chk("ar_alu", 64'(aluo[i]), 64'd0);
      chk("ar_mw", 64'(mwo[i]), 64'd0);
    end
    chk("ar_stall0", 64'(stall0), 64'd0);
    chk("ar_stall1", 64'(stall1), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ordy[0] = 1'b1;
    drive(0, 1'b1, 32'h99, 1'b0);
    step();
    drive(0, 1'b0, 32'h0, 1'b0);
    chk("post_rst_alu", 64'(aluo[0]), 64'h99);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
